leitor_caminho: RTL
===================

// Module: leitor_caminho
// PURPOSE
//  Return-direction counterpart of the fonte/destino start command.
//  Runs after the search core finishes. Walks the parent-pointer memory backwards from destino to fonte.
//  Streams each node address out on a valid/ready interface, destino first and fonte last.
//  Sits between the parent memory read port and the external path consumer.
// PARAMETERS
//  ADDR_WIDTH  10    node address width; parent memory holds 2**ADDR_WIDTH entries
//  MAX_PASSOS  1023  max parent reads per path; exceeding it flags erro (loop guard)
// PORTS
//  clk                     in   1           system clock, rising edge
//  rst_n                   in   1           asynchronous active-low reset
//  leitor_inicio_in        in   1           1-cycle pulse: path found, start readback
//  leitor_addr_fonte_in    in   ADDR_WIDTH  source node, sampled with inicio
//  leitor_addr_destino_in  in   ADDR_WIDTH  destination node, sampled with inicio
//  leitor_rd_en_out        out  1           parent memory read strobe
//  leitor_rd_addr_out      out  ADDR_WIDTH  parent memory read address
//  leitor_rd_data_in       in   ADDR_WIDTH  parent of rd_addr, valid 1 cycle after rd_en
//  leitor_no_out           out  ADDR_WIDTH  current path node
//  leitor_no_valid_out     out  1           leitor_no_out is valid
//  leitor_no_ready_in      in   1           consumer accepts the node
//  leitor_no_ultimo_out    out  1           current node is fonte (last beat)
//  leitor_ocupado_out      out  1           readback in progress
//  leitor_fim_out          out  1           1-cycle pulse: last node accepted
//  leitor_erro_out         out  1           1-cycle pulse: walk aborted
// BEHAVIOUR
//  Reset: all outputs 0; state OCIOSO; internal regs 0. Asserting rst_n low mid-walk aborts at once.
//    No fim or erro pulse is emitted on such an abort.
//  FSM states: OCIOSO, EMITIR, LER, ERRO.
//  OCIOSO:
//    - On inicio: latch fonte and destino; no_atual <= destino; passos <= 0; go to EMITIR.
//    - ocupado rises on the next cycle.
//  EMITIR:
//    - valid=1, no_out=no_atual, ultimo=(no_atual==fonte).
//    - Beat transfers on a cycle where valid && ready.
//    - After a transfer with ultimo=1: fim pulses next cycle; go to OCIOSO.
//    - After a transfer with ultimo=0: rd_en=1 with rd_addr=no_atual in the same cycle; passos++; go to LER.
//  LER:
//    - valid=0; rd_data is sampled in this cycle.
//    - If rd_data==no_atual (self-parent) or passos>MAX_PASSOS: go to ERRO.
//    - Otherwise no_atual <= rd_data; go to EMITIR.
//  ERRO: erro=1 for one cycle, then OCIOSO. ocupado is 1 in EMITIR, LER and ERRO.
//  Handshake:
//    - Once valid=1, valid and no_out stay stable until accepted.
//    - ready may be high before valid; a transfer takes 1 cycle.
//  Throughput: at best 1 node per 2 cycles. Latency inicio -> first valid: 1 cycle.
//  Boundaries:
//    - inicio while ocupado: ignored.
//    - fonte==destino: a single beat with ultimo=1 and no memory read.
//    - passos is ADDR_WIDTH+1 bits, so it cannot wrap before the limit check.
//    - ready held low indefinitely: the FSM stalls in EMITIR; there is no timeout.
// CONFIGURATION
//  LEITOR_COMPRIMENTO_EN defined:
//    - Adds port leitor_comprimento_out, out, ADDR_WIDTH+1 bits.
//    - It carries the number of nodes accepted in the last completed path.
//    - Updated in the same cycle fim pulses; holds until the next fim; reset 0.
//    - It is not updated on erro.
//  LEITOR_COMPRIMENTO_EN undefined: the port and its counter are absent; all other behaviour is identical.
// TESTING
//  T1:
//    - Setup: mem[12]=7, mem[7]=3, mem[3]=0; inicio with fonte=0, destino=12; ready=1.
//    - Expect: beats 12,7,3,0; ultimo only on 0; fim once; comprimento=4.
//  T2:
//    - Setup: fonte=destino=5.
//    - Expect: one beat 5 with ultimo=1; rd_en never asserted; fim pulses; comprimento=1.
//  T3:
//    - Setup: T1 path; ready toggles 0/1 randomly.
//    - Expect: no_out stable while valid && !ready; the same 4 beats in order.
//  T4:
//    - Setup: mem[9]=9; fonte=0, destino=9.
//    - Expect: beat 9 accepted, then erro pulses; no fim; ocupado drops; comprimento unchanged.
//  T5:
//    - Setup: MAX_PASSOS=3; cycle mem[4]=6, mem[6]=4; destino=4.
//    - Expect: erro after the 4th read; nodes emitted 4,6,4,6.
//  T6:
//    - Setup: T1 with rst_n pulsed low while in LER.
//    - Expect: all outputs 0 asynchronously; after release, a new inicio replays the full path 12,7,3,0.

Source files
------------

// File: rtl/leitor_caminho_if.sv
// Bus bundle for the path reader: start command, parent-memory read port, node stream.
// LEITOR_COMPRIMENTO_EN adds the path-length output to the bundle.
interface leitor_caminho_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  leitor_inicio_in;
    logic [ADDR_WIDTH-1:0] leitor_addr_fonte_in;
    logic [ADDR_WIDTH-1:0] leitor_addr_destino_in;
    logic                  leitor_rd_en_out;
    logic [ADDR_WIDTH-1:0] leitor_rd_addr_out;
    logic [ADDR_WIDTH-1:0] leitor_rd_data_in;
    logic [ADDR_WIDTH-1:0] leitor_no_out;
    logic                  leitor_no_valid_out;
    logic                  leitor_no_ready_in;
    logic                  leitor_no_ultimo_out;
    logic                  leitor_ocupado_out;
    logic                  leitor_fim_out;
    logic                  leitor_erro_out;
`ifdef LEITOR_COMPRIMENTO_EN
    logic [ADDR_WIDTH:0]   leitor_comprimento_out;

    modport slave (
        input  leitor_inicio_in, leitor_addr_fonte_in, leitor_addr_destino_in,
               leitor_rd_data_in, leitor_no_ready_in,
        output leitor_rd_en_out, leitor_rd_addr_out, leitor_no_out, leitor_no_valid_out,
               leitor_no_ultimo_out, leitor_ocupado_out, leitor_fim_out, leitor_erro_out,
               leitor_comprimento_out
    );

    modport master (
        output leitor_inicio_in, leitor_addr_fonte_in, leitor_addr_destino_in,
               leitor_rd_data_in, leitor_no_ready_in,
        input  leitor_rd_en_out, leitor_rd_addr_out, leitor_no_out, leitor_no_valid_out,
               leitor_no_ultimo_out, leitor_ocupado_out, leitor_fim_out, leitor_erro_out,
               leitor_comprimento_out
    );
`else
    modport slave (
        input  leitor_inicio_in, leitor_addr_fonte_in, leitor_addr_destino_in,
               leitor_rd_data_in, leitor_no_ready_in,
        output leitor_rd_en_out, leitor_rd_addr_out, leitor_no_out, leitor_no_valid_out,
               leitor_no_ultimo_out, leitor_ocupado_out, leitor_fim_out, leitor_erro_out
    );

    modport master (
        output leitor_inicio_in, leitor_addr_fonte_in, leitor_addr_destino_in,
               leitor_rd_data_in, leitor_no_ready_in,
        input  leitor_rd_en_out, leitor_rd_addr_out, leitor_no_out, leitor_no_valid_out,
               leitor_no_ultimo_out, leitor_ocupado_out, leitor_fim_out, leitor_erro_out
    );
`endif
endinterface

// File: rtl/leitor_caminho.sv
// Walks the parent-pointer memory from destino back to fonte, streaming each node.
// Optional LEITOR_COMPRIMENTO_EN reports the node count of the last completed path.
module leitor_caminho #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_PASSOS = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    leitor_caminho_if.slave  bus
);
    typedef enum logic [1:0] {OCIOSO, EMITIR, LER, ERRO} estado_t;

    localparam logic [ADDR_WIDTH:0] PASSOS_LIM = (ADDR_WIDTH+1)'(MAX_PASSOS);

    estado_t               estado, estado_prox;
    logic [ADDR_WIDTH-1:0] fonte;
    logic [ADDR_WIDTH-1:0] no_atual;
    logic [ADDR_WIDTH:0]   passos;
    logic                  fim_q;
    logic                  emitindo;
    logic                  ultimo;
    logic                  transfer;
    logic                  aborta;

    assign emitindo = (estado == EMITIR);
    assign ultimo   = emitindo && (no_atual == fonte);
    assign transfer = emitindo && bus.leitor_no_ready_in;
    // Self-parent or too many reads both mean the parent chain never reaches fonte.
    assign aborta   = (bus.leitor_rd_data_in == no_atual) || (passos > PASSOS_LIM);

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO: if (bus.leitor_inicio_in) estado_prox = EMITIR;
            EMITIR: if (transfer) estado_prox = ultimo ? OCIOSO : LER;
            LER:    estado_prox = aborta ? ERRO : EMITIR;
            ERRO:   estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= OCIOSO;
            fonte    <= '0;
            no_atual <= '0;
            passos   <= '0;
            fim_q    <= 1'b0;
        end else begin
            estado <= estado_prox;
            fim_q  <= transfer && ultimo;
            if (estado == OCIOSO && bus.leitor_inicio_in) begin
                fonte    <= bus.leitor_addr_fonte_in;
                no_atual <= bus.leitor_addr_destino_in;
                passos   <= '0;
            end
            if (transfer && !ultimo)
                passos <= passos + 1'b1;
            if (estado == LER && !aborta)
                no_atual <= bus.leitor_rd_data_in;
        end
    end

`ifdef LEITOR_COMPRIMENTO_EN
    logic [ADDR_WIDTH:0] contagem;
    logic [ADDR_WIDTH:0] comprimento;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contagem    <= '0;
            comprimento <= '0;
        end else begin
            if (estado == OCIOSO && bus.leitor_inicio_in)
                contagem <= '0;
            else if (transfer)
                contagem <= contagem + 1'b1;
            if (transfer && ultimo)
                comprimento <= contagem + 1'b1;
        end
    end

    assign bus.leitor_comprimento_out = comprimento;
`endif

    assign bus.leitor_no_valid_out  = emitindo;
    assign bus.leitor_no_out        = emitindo ? no_atual : '0;
    assign bus.leitor_no_ultimo_out = ultimo;
    assign bus.leitor_rd_en_out     = transfer && !ultimo;
    assign bus.leitor_rd_addr_out   = (transfer && !ultimo) ? no_atual : '0;
    assign bus.leitor_ocupado_out   = (estado != OCIOSO);
    assign bus.leitor_fim_out       = fim_q;
    assign bus.leitor_erro_out      = (estado == ERRO);
endmodule
